// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed first-word-fall-through FIFO.
package sram_fifo_pkg;

    localparam int unsigned OBUF_DEPTH        = 2;
    localparam int unsigned SRAM_READ_LATENCY = 1;

    // Words can sit in the SRAM, in the read pipeline and in the output buffer.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + SRAM_READ_LATENCY + OBUF_DEPTH);
    endfunction

endpackage

// File: rtl/dual_port_sram.sv
// Simple dual-port SRAM: one write port, one read port, registered read data (1-cycle latency).
module dual_port_sram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     chip_select,
    input  logic                     write_enable,
    input  logic                     output_enable,
    input  logic [$clog2(DEPTH)-1:0] write_address,
    input  logic [$clog2(DEPTH)-1:0] read_address,
    input  logic [WIDTH-1:0]         write_data,
    output logic [WIDTH-1:0]         read_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (chip_select && write_enable) begin
            mem_q[write_address] <= write_data;
        end
        if (chip_select && output_enable) begin
            rdata_q <= mem_q[read_address];
        end
    end

    assign read_data = rdata_q;

endmodule

// File: rtl/sram_fifo.sv
// First-word-fall-through FIFO on dual_port_sram; a 2-entry output buffer hides the read latency.
module sram_fifo
    import sram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(DEPTH + 1);
    localparam int unsigned CW = count_width(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [SW-1:0]    sram_count_q, sram_count_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       obuf_count_q, obuf_count_d, obuf_occ;
    logic [WIDTH-1:0] obuf_q [OBUF_DEPTH];
    logic [WIDTH-1:0] obuf_d [OBUF_DEPTH];
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, issue;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        push = in_valid && in_ready_q;
        pop  = out_valid_q && out_ready;
        // Counting the slot freed by this cycle's pop keeps one word per cycle flowing.
        obuf_occ = obuf_count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue    = (sram_count_q != '0) && (obuf_occ < 2'(OBUF_DEPTH));

        wptr_d     = push  ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = issue ? rptr_q + AW'(1) : rptr_q;
        inflight_d = issue;

        sram_count_d = sram_count_q;
        if (push && !issue) begin
            sram_count_d = sram_count_q + SW'(1);
        end else if (!push && issue) begin
            sram_count_d = sram_count_q - SW'(1);
        end

        obuf_d       = obuf_q;
        obuf_count_d = obuf_count_q;
        if (pop) begin
            obuf_d[0]    = obuf_q[1];
            obuf_count_d = obuf_count_d - 2'd1;
        end
        if (inflight_q) begin
            obuf_d[obuf_count_d[0]] = rdata;
            obuf_count_d            = obuf_count_d + 2'd1;
        end

        out_valid_d = (obuf_count_d != 2'd0);
        in_ready_d  = (sram_count_d < SW'(DEPTH));
        count_d     = CW'(sram_count_d) + CW'(inflight_d) + CW'(obuf_count_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            sram_count_q <= '0;
            inflight_q   <= 1'b0;
            obuf_count_q <= 2'd0;
            obuf_q       <= '{default: '0};
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            count_q      <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            sram_count_q <= sram_count_d;
            inflight_q   <= inflight_d;
            obuf_count_q <= obuf_count_d;
            obuf_q       <= obuf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            count_q      <= count_d;
        end
    end

    dual_port_sram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_sram (
        .clk          (clk),
        .chip_select  (push | issue),
        .write_enable (push),
        .output_enable(issue),
        .write_address(wptr_q),
        .read_address (rptr_q),
        .write_data   (in_data),
        .read_data    (rdata)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = obuf_q[0];
    assign count     = count_q;

endmodule

// File: tb/tb_sram_fifo.sv
// Randomized bench for sram_fifo against a queue model of accepted-but-not-popped words.
module tb_sram_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CAP   = DEPTH + 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       count;

    sram_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_vec;
    int unsigned      n_err;
    logic [WIDTH-1:0] q [$];
    logic             stalled;
    logic [WIDTH-1:0] stall_data;
    logic             last_push;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then apply the edge's handshakes.
    task automatic cycle();
        logic             push, pop;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        d    = in_data;
        check("count", 64'(count), 64'(q.size()));
        check("count_cap", 64'(count <= 5'(CAP)), 64'd1);
        if (q.size() == 0) check("empty_valid", 64'(out_valid), 64'd0);
        if (out_valid && q.size() > 0) check("head_data", 64'(out_data), 64'(q[0]));
        if (q.size() == CAP) check("full_ready", 64'(in_ready), 64'd0);
        if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(stall_data));
        end
        stalled    = out_valid && !out_ready;
        stall_data = out_data;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        last_push = push;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() != 0; i++) cycle();
        cycle();
        check("drain_count", 64'(count), 64'd0);
    endtask

    int unsigned accepted;
    int unsigned seen;

    initial begin
        n_vec = 0; n_err = 0; stalled = 1'b0; last_push = 1'b0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Single word: visible after the second edge following the push
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("lat_e0_valid", 64'(out_valid), 64'd0);
        cycle();
        check("lat_e1_valid", 64'(out_valid), 64'd0);
        cycle();
        check("lat_e2_valid", 64'(out_valid), 64'd1);
        check("lat_e2_data", 64'(out_data), 64'hDEADBEEF);
        cycle();
        check("single_count", 64'(count), 64'd0);

        // Fill with the consumer stalled: exactly DEPTH+2 of 20 offers accepted
        out_ready = 1'b0; accepted = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            cycle();
            if (last_push) accepted++;
        end
        in_valid = 1'b0;
        check("fill_accepted", 64'(accepted), 64'(CAP));
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_count", 64'(count), 64'(CAP));
        drain();

        // Streaming with pointer wrap: no bubble once the pipeline has filled
        out_ready = 1'b1;
        for (int i = 0; i < 44; i++) begin
            in_valid = (i < 40);
            in_data  = $urandom;
            cycle();
            if (i >= 2 && i <= 41) check("stream_valid", 64'(out_valid), 64'd1);
            else if (i < 2) check("stream_fill", 64'(out_valid), 64'd0);
        end
        drain();

        // Random backpressure
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_data   = $urandom;
            cycle();
        end
        drain();

        // Full boundary: pop at full, then push+pop together, then push to full again
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_data = $urandom;
            cycle();
        end
        check("bnd_full", 64'(count), 64'(CAP));
        out_ready = 1'b1; in_data = $urandom;
        cycle();
        check("bnd_pop_count", 64'(count), 64'(CAP - 1));
        check("bnd_pop_ready", 64'(in_ready), 64'd1);
        in_data = $urandom;
        cycle();
        check("bnd_both_count", 64'(count), 64'(CAP - 1));
        out_ready = 1'b0; in_data = $urandom;
        cycle();
        check("bnd_refill_count", 64'(count), 64'(CAP));
        check("bnd_refill_ready", 64'(in_ready), 64'd0);
        drain();

        // Reset with words held and a read in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'(100 + i);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        q.delete(); stalled = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0; seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            if (out_valid) begin
                check("post_rst_first", 64'(out_data), 64'h5);
                seen = 1;
            end
            cycle();
        end
        check("post_rst_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 6; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
